lfsr_checker8: RTL and testbench

Serial pseudo-random bit-sequence checker for the 8-bit Fibonacci LFSR generator. The generator uses polynomial x^8+x^6+x^5+x^4+1, taps 7/5/4/3 and period 255, and emits its feedback bit each cycle. This block sits at the receive end of a link or loopback path, takes the serial stream and self-synchronises to it. Once locked, it flags and counts every bit error and reports loss of lock. It is the receive-side counterpart of the LFSR pattern source used for link and loopback testing.

---
 rtl/lfsr_checker8.sv | 217 +++++++++++++++++++++
 tb/tb_lfsr_checker8.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker8.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_checker8
//  Purpose  : Receive-side checker for the 8-bit Fibonacci PRBS stream
//             (x^8+x^6+x^5+x^4+1, taps 7/5/4/3, period 255). Self-seeds
//             from the incoming bits, confirms the phase over LOCK_COUNT
//             correct predictions, then free-runs a local reference and
//             flags/counts every bit that disagrees with it.
//
//  Ports    : clk        rising-edge clock
//             reset      synchronous active-high reset
//             i          received serial bit
//             i_valid    qualifies i; with i_valid low all state holds
//             clr        synchronous clear of err_count
//             locked     registered, high while in the LOCKED state
//             err        registered one-cycle pulse per detected bit error
//             err_count  registered saturating 16-bit error count
//
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_checker8 #(
  parameter int LOCK_COUNT = 8,   // consecutive HUNT matches to lock (1..255)
  parameter int LOSS_COUNT = 4    // consecutive LOCKED misses to drop (1..15)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i,
  input  logic        i_valid,
  input  logic        clr,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_SEED = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  localparam logic [7:0]  LOCK_TARGET = 8'(LOCK_COUNT);
  localparam logic [3:0]  LOSS_TARGET = 4'(LOSS_COUNT);
  localparam logic [15:0] COUNT_MAX   = 16'hFFFF;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]  state;
  logic [1:0]  next_state;
  logic [7:0]  hist;        // history, hist[0] is the newest bit
  logic [2:0]  fill_cnt;    // bits collected while seeding
  logic [7:0]  match_cnt;   // consecutive correct predictions in HUNT
  logic [3:0]  loss_cnt;    // consecutive mismatches in LOCKED

  // Next values of the registered outputs
  logic        locked_d;
  logic        err_d;
  logic [15:0] err_count_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       pred;
  logic [7:0] hist_rx_shift;
  logic [7:0] hist_ref_shift;
  logic       hunt_match;
  logic       lock_miss;
  logic [7:0] match_inc;
  logic [3:0] loss_inc;
  logic       count_event;

  // Next generator bit predicted from the current history.
  assign pred = hist[7] ^ hist[5] ^ hist[4] ^ hist[3];

  // While seeding/hunting the received bit enters the history; once locked
  // the prediction does, so the reference free-runs and one corrupted bit
  // cannot contaminate later predictions.
  assign hist_rx_shift  = {hist[6:0], i};
  assign hist_ref_shift = {hist[6:0], pred};

  // An all-zero history is the LFSR lock-up state and never appears in a
  // real stream, so it is rejected even though it predicts 0 correctly.
  assign hunt_match = (i == pred) && (hist_rx_shift != 8'h00);
  assign lock_miss  = (i != pred);

  assign match_inc = match_cnt + 8'd1;
  assign loss_inc  = loss_cnt + 4'd1;

  // A counted error only exists for valid traffic in the LOCKED state.
  assign count_event = i_valid && (state == ST_LOCK) && lock_miss;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_SEED;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    if (i_valid) begin
      case (state)
        ST_SEED: begin
          if (fill_cnt == 3'd7) begin
            next_state = ST_HUNT;
          end
        end
        ST_HUNT: begin
          if (hunt_match && (match_inc == LOCK_TARGET)) begin
            next_state = ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (lock_miss && (loss_inc == LOSS_TARGET)) begin
            next_state = ST_SEED;
          end
        end
        default: begin
          next_state = ST_SEED;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output logic (next values for the output registers)
  // --------------------------------------------------------------------------
  always_comb begin
    // locked tracks the state being entered, so it falls on the same edge
    // that counts the loss-triggering error.
    locked_d    = (next_state == ST_LOCK);
    err_d       = count_event;
    err_count_d = err_count;
    if (count_event && (err_count != COUNT_MAX)) begin
      err_count_d = err_count + 16'd1;
    end
    // A clear coinciding with an error leaves that error counted.
    if (clr) begin
      err_count_d = {15'd0, count_event};
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= 16'd0;
    end else begin
      locked    <= locked_d;
      err       <= err_d;
      err_count <= err_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: history and the three run counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hist      <= 8'h00;
      fill_cnt  <= 3'd0;
      match_cnt <= 8'd0;
      loss_cnt  <= 4'd0;
    end else if (i_valid) begin
      case (state)
        ST_SEED: begin
          hist      <= hist_rx_shift;
          // Wraps 7 -> 0 on the eighth bit, ready for any later reseed.
          fill_cnt  <= fill_cnt + 3'd1;
          match_cnt <= 8'd0;
          loss_cnt  <= 4'd0;
        end
        ST_HUNT: begin
          hist     <= hist_rx_shift;
          fill_cnt <= 3'd0;
          loss_cnt <= 4'd0;
          // Cleared on a miss and also when lock is reached.
          if (hunt_match && (match_inc != LOCK_TARGET)) begin
            match_cnt <= match_inc;
          end else begin
            match_cnt <= 8'd0;
          end
        end
        ST_LOCK: begin
          hist      <= hist_ref_shift;
          fill_cnt  <= 3'd0;
          match_cnt <= 8'd0;
          // Cleared on a good bit and also when lock is dropped.
          if (lock_miss && (loss_inc != LOSS_TARGET)) begin
            loss_cnt <= loss_inc;
          end else begin
            loss_cnt <= 4'd0;
          end
        end
        default: begin
          hist      <= 8'h00;
          fill_cnt  <= 3'd0;
          match_cnt <= 8'd0;
          loss_cnt  <= 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lfsr_checker8
//  Purpose  : Self-checking bench for lfsr_checker8. Two instances: one with
//             default parameters, one with LOSS_COUNT=15 for the counter
//             saturation run. A behavioural model predicts outputs for both
//             each cycle; literal expectations pin key moments.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_checker8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_i, a_v, a_clr, a_locked, a_err;
  logic [15:0] a_cnt;
  logic        b_rst, b_i, b_v, b_clr, b_locked, b_err;
  logic [15:0] b_cnt;

  lfsr_checker8 #(.LOCK_COUNT(8), .LOSS_COUNT(4)) dut_a (
    .clk(clk), .reset(a_rst), .i(a_i), .i_valid(a_v), .clr(a_clr),
    .locked(a_locked), .err(a_err), .err_count(a_cnt)
  );

  lfsr_checker8 #(.LOCK_COUNT(8), .LOSS_COUNT(15)) dut_b (
    .clk(clk), .reset(b_rst), .i(b_i), .i_valid(b_v), .clr(b_clr),
    .locked(b_locked), .err(b_err), .err_count(b_cnt)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act == exp) passed = passed + 1;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  localparam logic [1:0] M_SEED = 2'd0;
  localparam logic [1:0] M_HUNT = 2'd1;
  localparam logic [1:0] M_LOCK = 2'd2;

  typedef struct packed {
    logic [1:0]  mode;
    logic [7:0]  h;
    int          fill;
    int          run;
    int          miss;
    logic        err;
    logic [15:0] cnt;
  } mdl_t;

  function automatic mdl_t mdl_step(input mdl_t m, input logic v, input logic b,
                                    input logic c, input int lock_n, input int loss_n);
    logic p;
    m.err = 1'b0;
    if (v) begin
      p = m.h[7] ^ m.h[5] ^ m.h[4] ^ m.h[3];
      if (m.mode == M_SEED) begin
        m.h = {m.h[6:0], b};
        m.fill = m.fill + 1;
        if (m.fill == 8) begin m.mode = M_HUNT; m.run = 0; end
      end else if (m.mode == M_HUNT) begin
        m.h = {m.h[6:0], b};
        if ((b == p) && (m.h != 8'h00)) m.run = m.run + 1;
        else m.run = 0;
        if (m.run == lock_n) begin m.mode = M_LOCK; m.miss = 0; end
      end else begin
        m.h = {m.h[6:0], p};
        if (b != p) begin
          m.err = 1'b1;
          if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
          m.miss = m.miss + 1;
          if (m.miss == loss_n) begin m.mode = M_SEED; m.fill = 0; end
        end else begin
          m.miss = 0;
        end
      end
    end
    if (c) m.cnt = {15'd0, m.err};
    return m;
  endfunction

  mdl_t ma, mb;
  bit   ready = 1'b0;

  always @(posedge clk) begin
    if (a_rst) ma = '0;
    else       ma = mdl_step(ma, a_v, a_i, a_clr, 8, 4);
    if (b_rst) mb = '0;
    else       mb = mdl_step(mb, b_v, b_i, b_clr, 8, 15);
    if (a_rst) ready = 1'b1;
  end

  always @(negedge clk) begin
    if (ready) begin
      chk("a_locked", int'(a_locked), int'(ma.mode == M_LOCK));
      chk("a_err",    int'(a_err),    int'(ma.err));
      chk("a_cnt",    int'(a_cnt),    int'(ma.cnt));
      chk("b_locked", int'(b_locked), int'(mb.mode == M_LOCK));
      chk("b_err",    int'(b_err),    int'(mb.err));
      chk("b_cnt",    int'(b_cnt),    int'(mb.cnt));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: each call spans one clock, inputs change 1 after edge
  // --------------------------------------------------------------------------
  logic [7:0] ga, gb;   // generator state per instance

  function automatic logic gen_bit(input logic [7:0] g);
    return g[7] ^ g[5] ^ g[4] ^ g[3];
  endfunction

  task automatic a_raw(input logic v, input logic b, input logic c);
    a_v = v; a_i = b; a_clr = c;
    @(posedge clk); #1;
    a_v = 1'b0; a_clr = 1'b0;
  endtask

  task automatic a_gen(input logic flip, input logic c);
    logic b;
    b  = gen_bit(ga);
    ga = {ga[6:0], b};
    a_raw(1'b1, b ^ flip, c);
  endtask

  task automatic a_clean(input int n);
    repeat (n) a_gen(1'b0, 1'b0);
  endtask

  task automatic b_gen(input logic flip);
    logic b;
    b  = gen_bit(gb);
    gb = {gb[6:0], b};
    b_v = 1'b1; b_i = b ^ flip; b_clr = 1'b0;
    @(posedge clk); #1;
    b_v = 1'b0;
  endtask

  bit seen_err, seen_lock;
  int r;

  initial begin
    a_rst = 1'b1; a_i = 1'b0; a_v = 1'b0; a_clr = 1'b0;
    b_rst = 1'b1; b_i = 1'b0; b_v = 1'b0; b_clr = 1'b0;
    ga = 8'h01; gb = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    a_rst = 1'b0;
    chk("rst_locked", int'(a_locked), 0);
    chk("rst_err",    int'(a_err),    0);
    chk("rst_cnt",    int'(a_cnt),    0);

    // Clean lock: 8 seed bits + 8 hunt matches
    a_clean(15);
    chk("lock_after15", int'(a_locked), 0);
    a_gen(1'b0, 1'b0);
    chk("lock_after16", int'(a_locked), 1);
    seen_err = 1'b0;
    repeat (1000) begin
      a_gen(1'b0, 1'b0);
      if (a_err) seen_err = 1'b1;
    end
    chk("clean_err_seen", int'(seen_err), 0);
    chk("clean_cnt",      int'(a_cnt),    0);

    // Three isolated single-bit errors
    for (int k = 0; k < 3; k++) begin
      a_clean(5);
      a_gen(1'b1, 1'b0);
      chk("single_err_pulse", int'(a_err), 1);
      a_gen(1'b0, 1'b0);
      chk("single_err_end", int'(a_err), 0);
      a_clean(5);
    end
    chk("single_cnt",    int'(a_cnt),    3);
    chk("single_locked", int'(a_locked), 1);

    // CLR without an error
    a_gen(1'b0, 1'b1);
    chk("clr_cnt", int'(a_cnt), 0);

    // Four consecutive errors drop lock on the fourth
    for (int k = 0; k < 4; k++) begin
      a_gen(1'b1, 1'b0);
      chk("loss_err",    int'(a_err),    1);
      chk("loss_locked", int'(a_locked), (k < 3) ? 1 : 0);
    end
    chk("loss_cnt", int'(a_cnt), 4);
    a_clean(15);
    chk("relock_after15", int'(a_locked), 0);
    a_gen(1'b0, 1'b0);
    chk("relock_after16", int'(a_locked), 1);
    chk("relock_cnt",     int'(a_cnt),    4);

    // Pseudo-random valid gaps on a clean locked stream
    seen_err = 1'b0;
    repeat (400) begin
      if ($urandom_range(0, 1) == 1) a_gen(1'b0, 1'b0);
      else a_raw(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (a_err) seen_err = 1'b1;
    end
    chk("gap_err_seen", int'(seen_err), 0);
    chk("gap_locked",   int'(a_locked), 1);
    chk("gap_cnt",      int'(a_cnt),    4);

    // CLR coinciding with an error
    a_gen(1'b1, 1'b1);
    chk("clr_err_cnt",   int'(a_cnt), 1);
    chk("clr_err_pulse", int'(a_err), 1);
    a_clean(3);

    // Reach a count of 5, then reset mid-lock
    repeat (4) begin
      a_gen(1'b1, 1'b0);
      a_clean(3);
    end
    chk("pre_rst_cnt",    int'(a_cnt),    5);
    chk("pre_rst_locked", int'(a_locked), 1);
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    chk("midrst_locked", int'(a_locked), 0);
    chk("midrst_err",    int'(a_err),    0);
    chk("midrst_cnt",    int'(a_cnt),    0);
    a_clean(15);
    chk("rst_relock15", int'(a_locked), 0);
    a_gen(1'b0, 1'b0);
    chk("rst_relock16", int'(a_locked), 1);

    // Stuck-at-zero input from reset
    a_rst = 1'b1;
    @(posedge clk); #1;
    a_rst = 1'b0;
    seen_lock = 1'b0;
    repeat (300) begin
      a_raw(1'b1, 1'b0, 1'b0);
      if (a_locked) seen_lock = 1'b1;
    end
    chk("stuck_lock_seen", int'(seen_lock), 0);
    chk("stuck_cnt",       int'(a_cnt),     0);

    // Randomised traffic: gaps, sparse errors and clears, model-checked
    repeat (3000) begin
      r = int'($urandom_range(0, 99));
      if (r < 25) a_raw(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0));
      else a_gen(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) == 0));
    end

    // Saturation on the LOSS_COUNT=15 instance: 14 errors then 1 good bit
    b_rst = 1'b0;
    repeat (16) b_gen(1'b0);
    chk("b_lock", int'(b_locked), 1);
    for (int g = 0; g < 4682; g++) begin
      repeat (14) b_gen(1'b1);
      b_gen(1'b0);
    end
    chk("b_sat_cnt",    int'(b_cnt),    65535);
    chk("b_sat_locked", int'(b_locked), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
